// File: rtl/mips_debug_unit.sv
// UART-driven loader/debug controller for the 5-stage MIPS pipeline: 8N1 RX/TX plus control FSM.
// Optional build macro DU_CMD_ECHO_EN: echo accepted IDLE commands on TX before acting on them.
module mips_debug_unit #(
    parameter int NB_REG       = 32,
    parameter int NB_R_INT     = 341,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                i_du_clk,
    input  logic                i_du_reset,
    input  logic                i_uart_rx_data_in,
    input  logic                i_du_halt,
    input  logic [NB_REG-1:0]   i_reg_data,
    input  logic [NB_REG-1:0]   i_mem_data,
    input  logic [NB_R_INT-1:0] i_latches_data,
    output logic                o_uart_tx_data_out,
    output logic [NB_REG-1:0]   o_mips_inst_data,
    output logic [NB_REG-1:0]   o_mips_inst_mem_addr_wr,
    output logic                o_mips_inst_mem_write_en,
    output logic                o_mips_inst_mem_read_en,
    output logic                o_mips_reset,
    output logic                o_tx_confirmation,
    output logic                o_rx_confirmation,
    output logic                o_idle_led,
    output logic                o_start_led,
    output logic                o_running_led
);
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int LAT_W  = ((NB_R_INT + 7) / 8) * 8;
    localparam int SNAP_W = 2 * NB_REG + LAT_W;
    localparam int NBYTES = SNAP_W / 8;
    localparam int BCW    = $clog2(NBYTES);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] BYTE_LAST = BCW'(NBYTES - 1);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CNT, S_LOAD_WORD, S_LOAD_WRITE,
        S_START, S_RUN, S_CAPTURE, S_SEND, S_ECHO
    } du_state_e;

    // ---------------- UART RX ----------------
    uart_state_e rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;
    logic [2:0]    rx_sync_q, rx_sync_d;
    logic          rx_s, rx_fall;

    // Two-flop synchronizer; bit 2 is the previous synced value for edge detection.
    assign rx_sync_d = {rx_sync_q[1:0], i_uart_rx_data_in};
    assign rx_s      = rx_sync_q[1];
    assign rx_fall   = rx_sync_q[2] & ~rx_s;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld_d = 1'b0;
        case (rx_st_q)
            U_IDLE: if (rx_fall) begin
                rx_st_d  = U_START;
                rx_cnt_d = '0;
            end
            U_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s ? U_IDLE : U_DATA;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            U_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = U_STOP;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            U_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_st_d  = U_IDLE;
                rx_vld_d = rx_s;
            end else rx_cnt_d = rx_cnt_q + 1'b1;
            default: rx_st_d = U_IDLE;
        endcase
    end

    // ---------------- UART TX ----------------
    uart_state_e tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_done_q, tx_done_d;
    logic          tx_start;
    logic [7:0]    tx_byte;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_done_d = 1'b0;
        case (tx_st_q)
            U_IDLE: if (tx_start) begin
                tx_sh_d  = tx_byte;
                tx_cnt_d = '0;
                tx_st_d  = U_START;
            end
            U_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                tx_st_d  = U_DATA;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
            U_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7) tx_st_d = U_STOP;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
            U_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_st_d   = U_IDLE;
                tx_done_d = 1'b1;
            end else tx_cnt_d = tx_cnt_q + 1'b1;
            default: tx_st_d = U_IDLE;
        endcase
    end

    assign o_uart_tx_data_out = (tx_st_q == U_START) ? 1'b0 :
                                (tx_st_q == U_DATA)  ? tx_sh_q[0] : 1'b1;

    // ---------------- Control FSM ----------------
    du_state_e          st_q, st_d;
    logic [NB_REG-1:0]  ptr_q, ptr_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [NB_REG-1:0]  inst_q, inst_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;
    logic [BCW-1:0]     sbyte_q, sbyte_d;
    logic               busy_q, busy_d;
    du_state_e          cmd_nxt;
    logic               cmd_ok;
`ifdef DU_CMD_ECHO_EN
    logic [7:0]         cmd_q, cmd_d;
    du_state_e          ret_q, ret_d;
`endif

    always_comb begin
        st_d     = st_q;
        ptr_d    = ptr_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        inst_d   = inst_q;
        snap_d   = snap_q;
        sbyte_d  = sbyte_q;
        busy_d   = busy_q;
        tx_start = 1'b0;
        tx_byte  = snap_q[7:0];
        cmd_nxt  = S_IDLE;
        cmd_ok   = 1'b0;
`ifdef DU_CMD_ECHO_EN
        cmd_d    = cmd_q;
        ret_d    = ret_q;
        if (st_q == S_ECHO) tx_byte = cmd_q;
`endif
        case (st_q)
            S_IDLE: if (rx_vld_q) begin
                case (rx_sh_q)
                    8'h01: begin cmd_nxt = S_LOAD_CNT; cmd_ok = 1'b1; end
                    8'h02: begin cmd_nxt = S_START;    cmd_ok = 1'b1; end
                    8'h0D: begin ptr_d = '0;           cmd_ok = 1'b1; end
                    default: ;
                endcase
`ifdef DU_CMD_ECHO_EN
                if (cmd_ok) begin
                    cmd_d  = rx_sh_q;
                    ret_d  = cmd_nxt;
                    busy_d = 1'b0;
                    st_d   = S_ECHO;
                end
`else
                st_d = cmd_nxt;
`endif
            end
            S_ECHO: begin
                if (!busy_q) begin
                    tx_start = 1'b1;
                    busy_d   = 1'b1;
                end else if (tx_done_q) begin
                    busy_d = 1'b0;
`ifdef DU_CMD_ECHO_EN
                    st_d   = ret_q;
`else
                    st_d   = S_IDLE;
`endif
                end
            end
            S_LOAD_CNT: if (rx_vld_q) begin
                if (rx_sh_q == 8'h00) st_d = S_IDLE;
                else begin
                    wcnt_d = rx_sh_q;
                    ptr_d  = '0;
                    bcnt_d = '0;
                    st_d   = S_LOAD_WORD;
                end
            end
            // Shift bytes in from the top so the first byte ends up in [7:0].
            S_LOAD_WORD: if (rx_vld_q) begin
                inst_d = {rx_sh_q, inst_q[NB_REG-1:8]};
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == 2'd3) st_d = S_LOAD_WRITE;
            end
            S_LOAD_WRITE: begin
                ptr_d  = ptr_q + NB_REG'(4);
                wcnt_d = wcnt_q - 1'b1;
                bcnt_d = '0;
                st_d   = (wcnt_q == 8'd1) ? S_IDLE : S_LOAD_WORD;
            end
            S_START: st_d = S_RUN;
            S_RUN: begin
                if (rx_vld_q && rx_sh_q == 8'h0D) st_d = S_IDLE;
                else if (i_du_halt)               st_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                snap_d  = SNAP_W'({i_latches_data, i_mem_data, i_reg_data});
                sbyte_d = '0;
                busy_d  = 1'b0;
                st_d    = S_SEND;
            end
            S_SEND: begin
                if (!busy_q) begin
                    tx_start = 1'b1;
                    busy_d   = 1'b1;
                end else if (tx_done_q) begin
                    busy_d  = 1'b0;
                    snap_d  = {8'h00, snap_q[SNAP_W-1:8]};
                    sbyte_d = sbyte_q + 1'b1;
                    if (sbyte_q == BYTE_LAST) st_d = S_IDLE;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_du_clk) begin
        if (i_du_reset) begin
            rx_st_q   <= U_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_sync_q <= '1;
            tx_st_q   <= U_IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_done_q <= 1'b0;
            st_q      <= S_IDLE;
            ptr_q     <= '0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            inst_q    <= '0;
            snap_q    <= '0;
            sbyte_q   <= '0;
            busy_q    <= 1'b0;
`ifdef DU_CMD_ECHO_EN
            cmd_q     <= '0;
            ret_q     <= S_IDLE;
`endif
        end else begin
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_vld_q  <= rx_vld_d;
            rx_sync_q <= rx_sync_d;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_done_q <= tx_done_d;
            st_q      <= st_d;
            ptr_q     <= ptr_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            inst_q    <= inst_d;
            snap_q    <= snap_d;
            sbyte_q   <= sbyte_d;
            busy_q    <= busy_d;
`ifdef DU_CMD_ECHO_EN
            cmd_q     <= cmd_d;
            ret_q     <= ret_d;
`endif
        end
    end

    // Pipeline stays out of reset from RUN until the dump finishes.
    assign o_mips_reset             = !(st_q == S_RUN || st_q == S_CAPTURE || st_q == S_SEND);
    assign o_mips_inst_mem_read_en  = (st_q == S_RUN);
    assign o_mips_inst_mem_write_en = (st_q == S_LOAD_WRITE);
    assign o_mips_inst_mem_addr_wr  = ptr_q;
    assign o_mips_inst_data         = inst_q;
    assign o_tx_confirmation        = tx_done_q;
    assign o_rx_confirmation        = rx_vld_q;
    assign o_idle_led               = (st_q == S_IDLE);
    assign o_start_led              = (st_q == S_START);
    assign o_running_led            = (st_q == S_RUN);
endmodule

// File: tb/tb_mips_debug_unit.sv
// Scoreboard bench for mips_debug_unit: drives UART RX frames, decodes TX and write strobes.
module tb_mips_debug_unit;
    localparam int NB_REG = 32;
    localparam int NB_R_INT = 341;
    localparam int CPB = 10;
    localparam int GAP = 150;

    logic clk = 1'b0;
    logic rst, rx, halt;
    logic [NB_REG-1:0] reg_d, mem_d;
    logic [NB_R_INT-1:0] lat_d;
    logic tx, wr_en, rd_en, mrst, tx_conf, rx_conf, idle_led, start_led, run_led;
    logic [NB_REG-1:0] inst, addr;

    always #5 clk = ~clk;

    mips_debug_unit #(.NB_REG(NB_REG), .NB_R_INT(NB_R_INT), .CLKS_PER_BIT(CPB)) dut (
        .i_du_clk(clk), .i_du_reset(rst), .i_uart_rx_data_in(rx), .i_du_halt(halt),
        .i_reg_data(reg_d), .i_mem_data(mem_d), .i_latches_data(lat_d),
        .o_uart_tx_data_out(tx), .o_mips_inst_data(inst), .o_mips_inst_mem_addr_wr(addr),
        .o_mips_inst_mem_write_en(wr_en), .o_mips_inst_mem_read_en(rd_en),
        .o_mips_reset(mrst), .o_tx_confirmation(tx_conf), .o_rx_confirmation(rx_conf),
        .o_idle_led(idle_led), .o_start_led(start_led), .o_running_led(run_led)
    );

    int n_cmp = 0, n_err = 0;
    int tx_cnt = 0, tx_conf_cnt = 0, rx_conf_cnt = 0, wr_cnt = 0;
    logic [7:0] exp_tx_q[$];
    logic [NB_REG-1:0] exp_addr_q[$];
    logic [NB_REG-1:0] exp_data_q[$];
    logic [7:0] mon_byte;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // TX decoder: sample mid-bit and pop the expected byte.
    always begin
        @(negedge tx);
        repeat (CPB / 2) @(negedge clk);
        chk("tx_start_bit", tx, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        chk("tx_stop_bit", tx, 1);
        tx_cnt++;
        if (exp_tx_q.size() == 0) chk("tx_unexpected_byte", mon_byte, 64'h100);
        else chk("tx_byte", mon_byte, exp_tx_q.pop_front());
    end

    always @(negedge clk) begin
        if (rx_conf) rx_conf_cnt++;
        if (tx_conf) tx_conf_cnt++;
        if (wr_en) begin
            wr_cnt++;
            if (exp_addr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                chk("wr_addr", addr, exp_addr_q.pop_front());
                chk("wr_data", inst, exp_data_q.pop_front());
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic send_cmd(input logic [7:0] b);
`ifdef DU_CMD_ECHO_EN
        if (b == 8'h01 || b == 8'h02 || b == 8'h0D) exp_tx_q.push_back(b);
`endif
        send_byte(b);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (idle_led) break;
        end
        chk(tag, idle_led, 1);
    endtask

    int tx_before, rx_before, wr_before;
    logic [407:0] snap;

    initial begin
        rst = 1'b1; rx = 1'b1; halt = 1'b0;
        reg_d = '0; mem_d = '0; lat_d = '0;
        repeat (2) @(negedge clk);
        chk("rst_mips_reset", mrst, 1);
        chk("rst_idle_led", idle_led, 1);
        chk("rst_tx", tx, 1);
        chk("rst_write_en", wr_en, 0);
        chk("rst_read_en", rd_en, 0);
        chk("rst_leds", {start_led, run_led}, 0);
        chk("rst_inst_addr", {inst, addr}, 0);
        chk("rst_conf", {tx_conf, rx_conf}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Load two words
        exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'h12345678);
        exp_addr_q.push_back(32'd4); exp_data_q.push_back(32'hDEADBEEF);
        send_cmd(8'h01);
        send_byte(8'h02);
        foreach (snap[i]) snap[i] = 1'b0;
        begin
            logic [7:0] wb[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
            for (int i = 0; i < 8; i++) send_byte(wb[i]);
        end
        repeat (10) @(negedge clk);
        chk("load_idle", idle_led, 1);
        chk("load_writes", wr_cnt, 2);
        chk("load_rx_count", rx_conf_cnt, 10);

        // N=0 load returns straight to IDLE, then 0x0D and a single word reload at addr 0
        send_cmd(8'h01);
        send_byte(8'h00);
        repeat (10) @(negedge clk);
        chk("load0_idle", idle_led, 1);
        chk("load0_no_write", wr_cnt, 2);
        send_cmd(8'h0D);
        exp_addr_q.push_back(32'd0); exp_data_q.push_back(32'hCAFEF00D);
        send_cmd(8'h01);
        send_byte(8'h01);
        send_byte(8'h0D); send_byte(8'hF0); send_byte(8'hFE); send_byte(8'hCA);
        repeat (10) @(negedge clk);
        chk("load1_writes", wr_cnt, 3);
        chk("load1_idle", idle_led, 1);

        // Run then halt and dump
        reg_d = 32'h000000AA; mem_d = 32'h0000BEEF;
        for (int i = 0; i < NB_R_INT; i++) lat_d[i] = 1'($urandom_range(0, 1));
`ifdef DU_CMD_ECHO_EN
        exp_tx_q.push_back(8'h02);
`endif
        fork
            send_byte(8'h02);
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    if (start_led) break;
                end
                chk("run_start_led", start_led, 1);
                chk("run_start_mrst", mrst, 1);
                chk("run_echo_done", exp_tx_q.size(), 0);
                @(negedge clk);
                chk("run_start_1cyc", start_led, 0);
                chk("run_led", run_led, 1);
                chk("run_mrst", mrst, 0);
                chk("run_read_en", rd_en, 1);
            end
        join
        repeat (20) @(negedge clk);
        chk("run_hold", run_led, 1);
        tx_before = tx_cnt;
        snap = 408'({lat_d, mem_d, reg_d});
        for (int i = 0; i < 51; i++) exp_tx_q.push_back(snap[8*i +: 8]);
        halt = 1'b1;
        wait_idle("dump_idle", 12000);
        halt = 1'b0;
        repeat (5) @(negedge clk);
        chk("dump_bytes", tx_cnt - tx_before, 51);
        chk("dump_q_empty", exp_tx_q.size(), 0);
        chk("dump_mrst", mrst, 1);
        chk("tx_conf_count", tx_conf_cnt, tx_cnt);

        // Abort a run with 0x0D
        send_cmd(8'h02);
        chk("abort_running", run_led, 1);
        tx_before = tx_cnt;
        send_byte(8'h0D);
        repeat (3) @(negedge clk);
        chk("abort_run_led", run_led, 0);
        chk("abort_mrst", mrst, 1);
        chk("abort_idle", idle_led, 1);
        repeat (GAP) @(negedge clk);
        chk("abort_no_tx", tx_cnt, tx_before);

        // Invalid command, start-bit glitch, bad stop bit
        tx_before = tx_cnt; wr_before = wr_cnt; rx_before = rx_conf_cnt;
        send_cmd(8'h55);
        chk("inv_rx_seen", rx_conf_cnt, rx_before + 1);
        chk("inv_idle", idle_led, 1);
        chk("inv_no_write", wr_cnt, wr_before);
        chk("inv_no_tx", tx_cnt, tx_before);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_dropped", rx_conf_cnt, rx_before + 1);
        send_frame(8'h02, 1'b0);
        repeat (GAP) @(negedge clk);
        chk("badstop_dropped", rx_conf_cnt, rx_before + 1);
        chk("badstop_idle", idle_led, 1);
        chk("final_tx_q", exp_tx_q.size(), 0);
        chk("final_wr_q", exp_addr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
